m_axi_reg_master: RTL



---
 rtl/m_axi_reg_master.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/m_axi_reg_master.sv
// Single-beat AXI initiator: one read or write command at a time, response
// returned through a one-entry valid/ready port, plus completed-transaction counters.
module m_axi_reg_master #(
  parameter logic [3:0]  AXI_ID = 4'h0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [31:0]      cmd_addr_i,
  input  logic [31:0]      cmd_wdata_i,
  input  logic [3:0]       cmd_wstrb_i,
  output logic [3:0]       awid_o,
  output logic [31:0]      awaddr_o,
  output logic             awvalid_o,
  input  logic             awready_i,
  output logic [3:0]       wid_o,
  output logic [31:0]      wdata_o,
  output logic [3:0]       wstrb_o,
  output logic             wlast_o,
  output logic             wvalid_o,
  input  logic             wready_i,
  input  logic [3:0]       bid_i,
  input  logic [1:0]       bresp_i,
  input  logic             bvalid_i,
  output logic             bready_o,
  output logic [3:0]       arid_o,
  output logic [31:0]      araddr_o,
  output logic             arvalid_o,
  input  logic             arready_i,
  input  logic [3:0]       rid_i,
  input  logic [31:0]      rdata_i,
  input  logic [1:0]       rresp_i,
  input  logic             rlast_i,
  input  logic             rvalid_i,
  output logic             rready_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_write_o,
  output logic [31:0]      rsp_rdata_o,
  output logic [1:0]       rsp_resp_o,
  output logic [CNT_W-1:0] wr_count_o,
  output logic [CNT_W-1:0] rd_count_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_done, w_done;
  logic             rsp_write_q;
  logic [31:0]      rsp_rdata_q;
  logic [1:0]       rsp_resp_q;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  logic cmd_hs, aw_hs, w_hs, b_hs, r_hs, rsp_hs;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nx;
  end

  // AW and W are tracked independently; each valid is simply "not yet accepted"
  always_comb begin
    state_nx    = state;
    cmd_ready_o = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    bready_o    = 1'b0;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_nx = cmd_write_i ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        awvalid_o = !aw_done;
        wvalid_o  = !w_done;
        if ((aw_done || awready_i) && (w_done || wready_i)) state_nx = WR_RESP;
      end
      WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_nx = RSP;
      end
      RD_REQ: begin
        arvalid_o = 1'b1;
        if (arready_i) state_nx = RD_DATA;
      end
      RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) state_nx = RSP;
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_hs = cmd_valid_i & cmd_ready_o;
  assign aw_hs  = awvalid_o & awready_i;
  assign w_hs   = wvalid_o & wready_i;
  assign b_hs   = bvalid_i & bready_o;
  assign r_hs   = rvalid_i & rready_o;
  assign rsp_hs = rsp_valid_o & rsp_ready_i;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
    end else begin
      if (cmd_hs) begin
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        wstrb_q <= cmd_wstrb_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (b_hs) begin
        rsp_write_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= (bid_i == AXI_ID) ? bresp_i : 2'b10;
      end
      if (r_hs) begin
        rsp_write_q <= 1'b0;
        rsp_rdata_q <= rdata_i;
        rsp_resp_q  <= (rid_i == AXI_ID && rlast_i) ? rresp_i : 2'b10;
      end
      if (rsp_hs) begin
        if (rsp_write_q) wr_cnt <= wr_cnt + CNT_W'(1);
        else             rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

  // Byte offset is dropped on the bus; accesses are always word aligned
  assign awaddr_o    = addr_q & 32'hFFFF_FFFC;
  assign araddr_o    = addr_q & 32'hFFFF_FFFC;
  assign awid_o      = AXI_ID;
  assign wid_o       = AXI_ID;
  assign arid_o      = AXI_ID;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wlast_o     = wvalid_o;
  assign rsp_write_o = rsp_write_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;
  assign wr_count_o  = wr_cnt;
  assign rd_count_o  = rd_cnt;
  assign busy_o      = (state != IDLE);

endmodule
